// File: rtl/c880_bist_ctrl.sv
// BIST sequencer for the c880 core: LFSR pattern source, settle/capture timing,
// MISR response compaction and a golden-signature compare.
module c880_bist_ctrl #(
    parameter int NUM_PAT_W  = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [59:0]          seed,
    input  logic [NUM_PAT_W-1:0] num_pat,
    input  logic [25:0]          golden,
    output logic [59:0]          dut_in,
    input  logic [25:0]          dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [25:0]          signature,
    output logic [NUM_PAT_W-1:0] pat_idx
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_APPLY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0]           SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [NUM_PAT_W-1:0] PAT_ZERO    = {NUM_PAT_W{1'b0}};
    localparam logic [NUM_PAT_W-1:0] PAT_ONE     = {{(NUM_PAT_W-1){1'b0}}, 1'b1};

    // Fibonacci LFSR, x^60 + x^59 + 1
    function automatic logic [59:0] lfsr_step(input logic [59:0] s);
        return {s[58:0], s[59] ^ s[58]};
    endfunction

    // MISR, x^26 + x^6 + x^2 + x + 1, folding in one response word
    function automatic logic [25:0] misr_step(input logic [25:0] m, input logic [25:0] d);
        logic fb;
        fb = m[25] ^ m[5] ^ m[1] ^ m[0];
        return {m[24:0], fb} ^ d;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic [59:0]            lfsr_r;
    logic [59:0]            seed_r;
    logic [25:0]            misr_r;
    logic [25:0]            misr_next_s;
    logic [3:0]             cnt_r;
    logic [NUM_PAT_W-1:0]   pat_idx_r;
    logic [NUM_PAT_W-1:0]   num_pat_r;
    logic [25:0]            golden_r;
    logic [25:0]            signature_r;
    logic                   pass_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   last_pat_s;

    assign misr_next_s = misr_step(misr_r, dut_out);
    assign last_pat_s  = (pat_idx_r == (num_pat_r - PAT_ONE));

    // Next-state decode for the run sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_pat != PAT_ZERO) begin
                        state_next_s = ST_LOAD;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_next_s = ST_APPLY;
            ST_APPLY: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_APPLY;
                end
            end
            ST_CAPTURE: begin
                if (last_pat_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_APPLY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Datapath: run parameters, LFSR, settle counter, MISR and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r      <= 60'h0;
            seed_r      <= 60'h0;
            misr_r      <= 26'h0;
            cnt_r       <= 4'd0;
            pat_idx_r   <= PAT_ZERO;
            num_pat_r   <= PAT_ZERO;
            golden_r    <= 26'h0;
            signature_r <= 26'h0;
            pass_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        seed_r    <= seed;
                        num_pat_r <= num_pat;
                        golden_r  <= golden;
                        if (num_pat == PAT_ZERO) begin
                            signature_r <= 26'h0;
                            pass_r      <= (golden == 26'h0);
                        end else begin
                            pass_r <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    // An all-zero seed would lock the LFSR at zero
                    lfsr_r    <= (seed_r == 60'h0) ? 60'h1 : seed_r;
                    misr_r    <= 26'h0;
                    pat_idx_r <= PAT_ZERO;
                    cnt_r     <= 4'd0;
                end
                ST_APPLY: begin
                    if (cnt_r != SETTLE_LAST) begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    misr_r <= misr_next_s;
                    lfsr_r <= lfsr_step(lfsr_r);
                    cnt_r  <= 4'd0;
                    if (last_pat_s) begin
                        signature_r <= misr_next_s;
                        pass_r      <= (misr_next_s == golden_r);
                    end else begin
                        pat_idx_r <= pat_idx_r + PAT_ONE;
                    end
                end
                ST_DONE: begin
                    cnt_r <= 4'd0;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign dut_in    = lfsr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign signature = signature_r;
    assign pat_idx   = pat_idx_r;

endmodule

// File: tb/tb_c880_bist_ctrl.sv
// Self-checking bench for c880_bist_ctrl: per-run expectations are queued at
// launch and compared when done pulses.
module tb_c880_bist_ctrl;

    localparam int NW = 16;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [59:0]   seed = 60'h0;
    logic [NW-1:0] num_pat = '0;
    logic [25:0]   golden = 26'h0;
    logic [59:0]   dut_in;
    logic [25:0]   dut_out;
    logic          busy, done, pass;
    logic [25:0]   signature;
    logic [NW-1:0] pat_idx;

    logic          use_fn = 1'b0;
    logic [25:0]   const_out = 26'h0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [25:0] sig;
        logic        pass;
        int          lat;
    } exp_t;
    exp_t sb[$];

    function automatic logic [59:0] lfsr_f(input logic [59:0] s);
        return {s[58:0], s[59] ^ s[58]};
    endfunction

    function automatic logic [25:0] misr_f(input logic [25:0] m, input logic [25:0] d);
        return {m[24:0], m[25] ^ m[5] ^ m[1] ^ m[0]} ^ d;
    endfunction

    function automatic logic [25:0] core_f(input logic [59:0] d);
        return d[25:0] ^ d[51:26];
    endfunction

    function automatic logic [25:0] model_sig(input logic [59:0] s, input int n,
                                               input logic fn, input logic [25:0] co);
        logic [59:0] l;
        logic [25:0] m;
        l = (s == 60'h0) ? 60'h1 : s;
        m = 26'h0;
        for (int i = 0; i < n; i++) begin
            m = misr_f(m, fn ? core_f(l) : co);
            l = lfsr_f(l);
        end
        return m;
    endfunction

    assign dut_out = use_fn ? core_f(dut_in) : const_out;

    c880_bist_ctrl #(.NUM_PAT_W(NW), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_pat(num_pat),
        .golden(golden), .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
        .done(done), .pass(pass), .signature(signature), .pat_idx(pat_idx)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of cycle 1 of the run.
    task automatic launch(input logic [59:0] s, input int n, input logic [25:0] g);
        exp_t e;
        e.sig  = model_sig(s, n, use_fn, const_out);
        e.pass = (e.sig == g);
        e.lat  = (n == 0) ? 1 : 2 + n * (SC + 1);
        sb.push_back(e);
        start = 1'b1; seed = s; num_pat = NW'(n); golden = g;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int budget, output int lat);
        lat = -1;
        for (int c = c0; c <= budget; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (dut_in !== 60'h0)    begin errors++; $display("FAIL reset_dut_in got %h exp 0", dut_in); end
        checks++; if (signature !== 26'h0) begin errors++; $display("FAIL reset_sig got %h exp 0", signature); end
        checks++; if (pat_idx !== '0)      begin errors++; $display("FAIL reset_pat_idx got %h exp 0", pat_idx); end
        checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, pass}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [59:0] one60;
        exp_t e;
        int lat;
        one60 = 60'h1;
        lat = -1;
        use_fn = 1'b0; const_out = 26'h3;
        @(negedge clk);
        launch(60'h1, 3, 26'h0ABCDE);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (busy !== (c <= 11)) begin errors++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, (c <= 11)); end
            checks++;
            if (done !== (c == 11)) begin errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, done, (c == 11)); end
            if (done === 1'b1 && lat < 0) lat = c;
            if (c >= 2 && c <= 10) begin
                checks++;
                if (dut_in !== (one60 << ((c - 2) / 3))) begin
                    errors++; $display("FAIL basic_dut_in c=%0d got %h exp %h", c, dut_in, one60 << ((c - 2) / 3));
                end
                checks++;
                if (pat_idx !== NW'((c - 2) / 3)) begin
                    errors++; $display("FAIL basic_pat_idx c=%0d got %0d exp %0d", c, pat_idx, (c - 2) / 3);
                end
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++; if (lat !== e.lat)        begin errors++; $display("FAIL basic_lat got %0d exp %0d", lat, e.lat); end
        checks++; if (signature !== e.sig)  begin errors++; $display("FAIL basic_sig got %h exp %h", signature, e.sig); end
        checks++; if (pass !== e.pass)      begin errors++; $display("FAIL basic_pass got %b exp %b", pass, e.pass); end
    endtask

    task automatic test_seed_zero();
        exp_t e;
        int lat;
        use_fn = 1'b0; const_out = 26'h7;
        @(negedge clk);
        launch(60'h0, 1, 26'h7);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (dut_in !== 60'h1) begin errors++; $display("FAIL seed0_dut_in c=%0d got %h exp 1", c, dut_in); end
        end
        wait_done(4, 40, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat)       begin errors++; $display("FAIL seed0_lat got %0d exp %0d", lat, e.lat); end
        checks++; if (signature !== e.sig) begin errors++; $display("FAIL seed0_sig got %h exp %h", signature, e.sig); end
        checks++; if (pass !== e.pass)     begin errors++; $display("FAIL seed0_pass got %b exp %b", pass, e.pass); end
    endtask

    task automatic test_misr();
        exp_t e;
        int lat;
        use_fn = 1'b0; const_out = 26'h1;
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            launch(60'h123456789ABCDEF, n, 26'h1);
            wait_done(1, 40, lat);
            e = sb.pop_front();
            checks++; if (lat !== e.lat)       begin errors++; $display("FAIL misr_lat n=%0d got %0d exp %0d", n, lat, e.lat); end
            checks++; if (signature !== e.sig) begin errors++; $display("FAIL misr_sig n=%0d got %h exp %h", n, signature, e.sig); end
            checks++; if (pass !== e.pass)     begin errors++; $display("FAIL misr_pass n=%0d got %b exp %b", n, pass, e.pass); end
            checks++;
            if (signature !== ((n == 1) ? 26'h1 : 26'h2)) begin
                errors++; $display("FAIL misr_sig_const n=%0d got %h exp %h", n, signature, (n == 1) ? 26'h1 : 26'h2);
            end
        end
    endtask

    task automatic test_zero_patterns();
        logic [25:0] g;
        exp_t e;
        int lat;
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? 26'h0 : 26'h5;
            @(negedge clk);
            launch(60'hF0F0, 0, g);
            wait_done(1, 10, lat);
            e = sb.pop_front();
            checks++; if (lat !== 1)           begin errors++; $display("FAIL zero_lat g=%h got %0d exp 1", g, lat); end
            checks++; if (signature !== 26'h0) begin errors++; $display("FAIL zero_sig g=%h got %h exp 0", g, signature); end
            checks++; if (pass !== e.pass)     begin errors++; $display("FAIL zero_pass g=%h got %b exp %b", g, pass, e.pass); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        use_fn = 1'b1;
        @(negedge clk);
        launch(60'hABCDE12345, 2, 26'h1234);
        @(negedge clk);
        start = 1'b1; num_pat = NW'(7); golden = 26'h3FFFFFF; seed = 60'h55;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 60, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat)       begin errors++; $display("FAIL b2b_lat got %0d exp %0d", lat, e.lat); end
        checks++; if (signature !== e.sig) begin errors++; $display("FAIL b2b_sig got %h exp %h", signature, e.sig); end
        checks++; if (pass !== e.pass)     begin errors++; $display("FAIL b2b_pass got %b exp %b", pass, e.pass); end
        start = 1'b1; seed = 60'h9876; num_pat = NW'(1); golden = 26'h0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done got busy %b exp 0", busy); end
        launch(60'h9876, 1, 26'h0);
        wait_done(1, 40, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat)       begin errors++; $display("FAIL b2b_rerun_lat got %0d exp %0d", lat, e.lat); end
        checks++; if (signature !== e.sig) begin errors++; $display("FAIL b2b_rerun_sig got %h exp %h", signature, e.sig); end
    endtask

    task automatic test_random();
        logic [59:0] s;
        logic [25:0] g;
        exp_t e;
        int n, lat;
        use_fn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = {28'($urandom), 32'($urandom)};
            n = $urandom_range(1, 5);
            g = (k % 2 == 0) ? model_sig(s, n, 1'b1, 26'h0) : 26'($urandom);
            @(negedge clk);
            launch(s, n, g);
            wait_done(1, 60, lat);
            e = sb.pop_front();
            checks++; if (lat !== e.lat)       begin errors++; $display("FAIL rand_lat k=%0d got %0d exp %0d", k, lat, e.lat); end
            checks++; if (signature !== e.sig) begin errors++; $display("FAIL rand_sig k=%0d got %h exp %h", k, signature, e.sig); end
            checks++; if (pass !== e.pass)     begin errors++; $display("FAIL rand_pass k=%0d got %b exp %b", k, pass, e.pass); end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int lat;
        use_fn = 1'b1;
        @(negedge clk);
        launch(60'h3C3C3C3C3C, 3, 26'h0);
        repeat (4) @(negedge clk);
        checks++; if (pat_idx !== NW'(1)) begin errors++; $display("FAIL rstmid_pre_idx got %0d exp 1", pat_idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dut_in !== 60'h0)    begin errors++; $display("FAIL rstmid_dut_in got %h exp 0", dut_in); end
        checks++; if (signature !== 26'h0) begin errors++; $display("FAIL rstmid_sig got %h exp 0", signature); end
        checks++; if (pat_idx !== '0)      begin errors++; $display("FAIL rstmid_pat_idx got %0d exp 0", pat_idx); end
        checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b exp 000", {busy, done, pass}); end
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_idle c=%0d got %b exp 00", c, {busy, done}); end
        end
        launch(60'h3C3C3C3C3C, 3, model_sig(60'h3C3C3C3C3C, 3, 1'b1, 26'h0));
        wait_done(1, 60, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat)       begin errors++; $display("FAIL rstmid_lat got %0d exp %0d", lat, e.lat); end
        checks++; if (signature !== e.sig) begin errors++; $display("FAIL rstmid_sig2 got %h exp %h", signature, e.sig); end
        checks++; if (pass !== 1'b1)       begin errors++; $display("FAIL rstmid_pass got %b exp 1", pass); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seed_zero();
        test_misr();
        test_zero_patterns();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
